// File: rtl/main_fsm.sv
// ----------------------------------------------------------------------------
// main_fsm
// Multicycle RISC-V control state machine. Steps each instruction through
// fetch, decode, execute, memory and writeback, one state per clock. It drives
// the datapath enables and mux selects, the 2-bit ALUOp for the ALU decoder,
// and the immediate format. MemReady lets instruction and data memory stretch
// FETCH, MEMREAD and MEMWRITE over several cycles.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   op[6:0]    in   Instr[6:0] from the instruction register
//   Zero       in   ALU zero flag (used in BEQ only)
//   MemReady   in   memory access completes this cycle
//   PCWrite    out  PC register enable
//   AdrSrc     out  memory address select (0 = PC, 1 = ALUOut)
//   IRWrite    out  instruction register enable (also latches OldPC)
//   MemWrite   out  data memory write strobe
//   RegWrite   out  register file write enable
//   ResultSrc  out  result mux select (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA    out  ALU A select (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB    out  ALU B select (00 rs2, 01 ImmExt, 10 const 4)
//   ALUOp      out  ALU decoder op (00 add, 01 sub, 10 funct-decoded)
//   ImmSrc     out  immediate format (00 I, 01 S, 10 B, 11 J)
//   IllegalOp  out  one-cycle pulse in DECODE on an unsupported opcode
//   State[3:0] out  current state, for debug
// ----------------------------------------------------------------------------
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = FETCH;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    IllegalOp  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;

    case (state_reg)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        pc_update = MemReady;
        state_next = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        // Precompute the branch target OldPC + ImmExt while decoding.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            state_next = FETCH;
            IllegalOp  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        // op[5] separates sw (0100011) from lw (0000011).
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        state_next = MemReady ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        branch     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        // ALU forms the link value OldPC + 4; PC takes the target from ALUOut.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase

    // Reset shows FETCH selects but suppresses every strobe, so an abandoned
    // instruction cannot write anything during the reset cycle.
    if (reset) begin
      AdrSrc    = 1'b0;
      ResultSrc = 2'b10;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b10;
      ALUOp     = 2'b00;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
    end
  end

  assign PCWrite = pc_update | (branch & Zero);
  assign State   = state_reg;

  // Immediate format follows the opcode alone, not the state.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule
